// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
// Shared definitions for the two-port memory arbiter: FSM state encoding,
// debug grant codes and a helper that maps a state to its grant code.
package mem_port_arbiter_pkg;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t ST_IDLE   = 2'd0;
    localparam arb_state_t ST_GNT_IC = 2'd1;
    localparam arb_state_t ST_GNT_DC = 2'd2;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_IC   = 2'b01;
    localparam logic [1:0] GRANT_DC   = 2'b10;

    function automatic logic [1:0] grant_of_state(input arb_state_t st);
        case (st)
            ST_GNT_IC: grant_of_state = GRANT_IC;
            ST_GNT_DC: grant_of_state = GRANT_DC;
            default:   grant_of_state = GRANT_NONE;
        endcase
    endfunction

endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// arb_pick
// Pure combinational winner select between the icache and dcache.
// Ports:
//   i_ic_act, i_dc_act : requester active flags
//   i_rr_mode          : 1 = round-robin, 0 = fixed dcache priority
//   i_last_dc          : round-robin history, 1 = dcache was granted last
//   i_promote_ic       : starvation promotion of the icache (fixed mode)
//   o_win              : one-hot winner {dcache, icache}, 00 when idle
module arb_pick (
    input  logic       i_ic_act,
    input  logic       i_dc_act,
    input  logic       i_rr_mode,
    input  logic       i_last_dc,
    input  logic       i_promote_ic,
    output logic [1:0] o_win
);

    logic w_ic_wins_tie;

    // On contention the icache wins only if it was not served last (round
    // robin) or has been starved long enough (fixed priority).
    assign w_ic_wins_tie = i_rr_mode ? i_last_dc : i_promote_ic;

    always_comb begin
        o_win = 2'b00;
        if (i_ic_act && i_dc_act) begin
            o_win = w_ic_wins_tie ? 2'b01 : 2'b10;
        end else if (i_dc_act) begin
            o_win = 2'b10;
        end else if (i_ic_act) begin
            o_win = 2'b01;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Arbitrates a single memory port between an icache (read only) and a
// dcache (read/write). The owner keeps the port for as long as it stays
// active; the memory bus combinationally mirrors the owner's request.
// Build option: ARB_ROUND_ROBIN_EN selects round-robin on contention;
// otherwise the dcache has fixed priority and a starved icache is promoted.
// Ports:
//   i_clk, i_rst            : clock, synchronous active-high reset
//   i_ic_* / o_ic_*         : icache request and response
//   i_dc_* / o_dc_*         : dcache request and response
//   o_mem_* / i_mem_*       : shared memory port
//   o_grant                 : debug, 00 none, 01 icache, 10 dcache
//
// state     | meaning
// ST_IDLE   | no owner, arbitrate among active requesters
// ST_GNT_IC | icache owns the memory port
// ST_GNT_DC | dcache owns the memory port
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_ic_ren,
    input  logic [DATA_W-1:0] i_ic_addr,
    output logic [DATA_W-1:0] o_ic_rdata,
    output logic              o_ic_valid,
    output logic              o_ic_ready,
    input  logic              i_dc_ren,
    input  logic              i_dc_wen,
    input  logic [DATA_W-1:0] i_dc_addr,
    input  logic [DATA_W-1:0] i_dc_wdata,
    output logic [DATA_W-1:0] o_dc_rdata,
    output logic              o_dc_valid,
    output logic              o_dc_ready,
    output logic [DATA_W-1:0] o_mem_addr,
    output logic              o_mem_ren,
    output logic              o_mem_wen,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    input  logic              i_mem_valid,
    input  logic              i_mem_ready,
    output logic [1:0]        o_grant
);

    arb_state_t r_state;
    arb_state_t w_next;
    logic       w_ic_act;
    logic       w_dc_act;
    logic       w_own_ic;
    logic       w_own_dc;
    logic [1:0] w_win;
    logic       w_rr_mode;
    logic       w_last_dc;
    logic       w_promote_ic;

    assign w_ic_act = i_ic_ren;
    assign w_dc_act = i_dc_ren | i_dc_wen;
    assign w_own_ic = (r_state == ST_GNT_IC);
    assign w_own_dc = (r_state == ST_GNT_DC);

`ifdef ARB_ROUND_ROBIN_EN
    logic r_last_dc;

    // Resets to "icache last" so the dcache wins the first contention.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_last_dc <= 1'b0;
        end else if (w_own_dc) begin
            r_last_dc <= 1'b1;
        end else if (w_own_ic) begin
            r_last_dc <= 1'b0;
        end
    end

    assign w_rr_mode    = 1'b1;
    assign w_last_dc    = r_last_dc;
    assign w_promote_ic = 1'b0;
`else
    localparam logic [4:0] C_STARVE = STARVE_LIMIT[4:0];

    logic [4:0] r_wait;

    // Counts cycles the icache waits; saturates rather than wrapping so a
    // long dcache tenure cannot hide the starvation.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wait <= 5'd0;
        end else if (w_own_ic) begin
            r_wait <= 5'd0;
        end else if (w_ic_act && (r_wait != 5'h1f)) begin
            r_wait <= r_wait + 5'd1;
        end
    end

    assign w_rr_mode    = 1'b0;
    assign w_last_dc    = 1'b0;
    assign w_promote_ic = (r_wait >= C_STARVE);
`endif

    arb_pick u_arb_pick (
        .i_ic_act     (w_ic_act),
        .i_dc_act     (w_dc_act),
        .i_rr_mode    (w_rr_mode),
        .i_last_dc    (w_last_dc),
        .i_promote_ic (w_promote_ic),
        .o_win        (w_win)
    );

    // The owner is never preempted; on release the port goes straight to the
    // other requester if it is waiting, skipping an IDLE cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_win[1]) begin
                    w_next = ST_GNT_DC;
                end else if (w_win[0]) begin
                    w_next = ST_GNT_IC;
                end
            end
            ST_GNT_IC: begin
                if (!w_ic_act) begin
                    w_next = w_dc_act ? ST_GNT_DC : ST_IDLE;
                end
            end
            ST_GNT_DC: begin
                if (!w_dc_act) begin
                    w_next = w_ic_act ? ST_GNT_IC : ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // With no owner every bus field is zero, so reset and IDLE look the same
    // on the memory side and a stray i_mem_valid reaches nobody.
    always_comb begin
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_mem_ren   = 1'b0;
        o_mem_wen   = 1'b0;
        if (w_own_ic) begin
            o_mem_addr = i_ic_addr;
            o_mem_ren  = i_ic_ren;
        end else if (w_own_dc) begin
            o_mem_addr  = i_dc_addr;
            o_mem_wdata = i_dc_wdata;
            o_mem_ren   = i_dc_ren;
            o_mem_wen   = i_dc_wen;
        end
    end

    assign o_ic_rdata = i_mem_rdata;
    assign o_dc_rdata = i_mem_rdata;
    assign o_ic_valid = w_own_ic & i_mem_valid;
    assign o_dc_valid = w_own_dc & i_mem_valid;
    assign o_ic_ready = w_own_ic & i_mem_ready;
    assign o_dc_ready = w_own_dc & i_mem_ready;
    assign o_grant    = grant_of_state(r_state);

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_ic_ren;
    logic [31:0] i_ic_addr;
    logic [31:0] o_ic_rdata;
    logic        o_ic_valid;
    logic        o_ic_ready;
    logic        i_dc_ren;
    logic        i_dc_wen;
    logic [31:0] i_dc_addr;
    logic [31:0] i_dc_wdata;
    logic [31:0] o_dc_rdata;
    logic        o_dc_valid;
    logic        o_dc_ready;
    logic [31:0] o_mem_addr;
    logic        o_mem_ren;
    logic        o_mem_wen;
    logic [31:0] o_mem_wdata;
    logic [31:0] i_mem_rdata;
    logic        i_mem_valid;
    logic        i_mem_ready;
    logic [1:0]  o_grant;

    int chk_cnt = 0;
    int err_cnt = 0;

    always #5 i_clk = ~i_clk;

    mem_port_arbiter #(.DATA_W(32), .STARVE_LIMIT(16)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_ic_ren    (i_ic_ren),
        .i_ic_addr   (i_ic_addr),
        .o_ic_rdata  (o_ic_rdata),
        .o_ic_valid  (o_ic_valid),
        .o_ic_ready  (o_ic_ready),
        .i_dc_ren    (i_dc_ren),
        .i_dc_wen    (i_dc_wen),
        .i_dc_addr   (i_dc_addr),
        .i_dc_wdata  (i_dc_wdata),
        .o_dc_rdata  (o_dc_rdata),
        .o_dc_valid  (o_dc_valid),
        .o_dc_ready  (o_dc_ready),
        .o_mem_addr  (o_mem_addr),
        .o_mem_ren   (o_mem_ren),
        .o_mem_wen   (o_mem_wen),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_rdata (i_mem_rdata),
        .i_mem_valid (i_mem_valid),
        .i_mem_ready (i_mem_ready),
        .o_grant     (o_grant)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        cyc();
        cyc();
        i_rst = 1'b0;
    endtask

    logic [1:0] g;
    logic [1:0] prev_g;
    logic [1:0] seq [0:7];
    logic [1:0] exp_tie;
    int         n_seq;
    int         idle_cnt;
    int         dc_cnt;
    int         ic_cnt;
    logic       dc_off;
    logic       ic_off;

    initial begin
        i_rst       = 1'b1;
        i_ic_ren    = 1'b0;
        i_ic_addr   = '0;
        i_dc_ren    = 1'b0;
        i_dc_wen    = 1'b0;
        i_dc_addr   = '0;
        i_dc_wdata  = '0;
        i_mem_rdata = '0;
        i_mem_valid = 1'b0;
        i_mem_ready = 1'b0;
        do_reset();

        check_val("rst_grant", 32'(o_grant), 0);
        check_val("rst_mem_ren", 32'(o_mem_ren), 0);
        check_val("rst_mem_wen", 32'(o_mem_wen), 0);
        check_val("rst_mem_addr", o_mem_addr, 0);
        i_mem_ready = 1'b1;
        #1;
        check_val("idle_ready_gated", 32'({o_ic_ready, o_dc_ready}), 0);

        // icache-only read at 0x100
        i_ic_ren  = 1'b1;
        i_ic_addr = 32'h100;
        #1;
        check_val("ic_arb_latency", 32'(o_grant), 0);
        cyc();
        check_val("ic_grant", 32'(o_grant), 1);
        check_val("ic_mem_addr", o_mem_addr, 32'h100);
        check_val("ic_mem_ren", 32'(o_mem_ren), 1);
        check_val("ic_ready", 32'(o_ic_ready), 1);
        i_mem_rdata = 32'hDEADBEEF;
        i_mem_valid = 1'b1;
        #1;
        check_val("ic_valid_pulse", 32'(o_ic_valid), 1);
        check_val("ic_rdata", o_ic_rdata, 32'hDEADBEEF);
        check_val("dc_rdata_shared", o_dc_rdata, 32'hDEADBEEF);
        check_val("dc_valid_gated", 32'(o_dc_valid), 0);
        check_val("dc_ready_gated", 32'(o_dc_ready), 0);
        i_mem_valid = 1'b0;
        #1;
        check_val("ic_valid_low", 32'(o_ic_valid), 0);
        i_ic_ren = 1'b0;
        cyc();
        check_val("ic_release_idle", 32'(o_grant), 0);
        check_val("idle_mem_ren", 32'(o_mem_ren), 0);

        // memory valid while idle is dropped
        i_mem_valid = 1'b1;
        #1;
        check_val("idle_valid_drop", 32'({o_ic_valid, o_dc_valid}), 0);
        cyc();
        check_val("idle_valid_nogrant", 32'(o_grant), 0);
        i_mem_valid = 1'b0;

        // simultaneous requests: dcache first, then icache with no IDLE gap
        i_dc_addr = 32'h200;
        i_ic_addr = 32'h104;
        i_dc_ren  = 1'b1;
        i_ic_ren  = 1'b1;
        cyc();
        check_val("both_dc_first", 32'(o_grant), 2);
        check_val("both_dc_addr", o_mem_addr, 32'h200);
        check_val("both_ic_ready0", 32'(o_ic_ready), 0);
        check_val("both_dc_ready", 32'(o_dc_ready), 1);
        i_dc_wen   = 1'b1;
        i_dc_wdata = 32'h55AA;
        #1;
        check_val("dc_mem_wen", 32'(o_mem_wen), 1);
        check_val("dc_mem_wdata", o_mem_wdata, 32'h55AA);
        cyc();
        check_val("dc_tenure_held", 32'(o_grant), 2);
        i_dc_ren = 1'b0;
        i_dc_wen = 1'b0;
        cyc();
        check_val("handoff_no_idle", 32'(o_grant), 1);
        check_val("handoff_ic_addr", o_mem_addr, 32'h104);
        check_val("handoff_wen0", 32'(o_mem_wen), 0);
        check_val("handoff_wdata0", o_mem_wdata, 0);
        i_ic_ren = 1'b0;
        cyc();
        check_val("both_end_idle", 32'(o_grant), 0);

        // reset during a dcache grant with valid high
        i_dc_ren = 1'b1;
        cyc();
        check_val("rstg_dc_grant", 32'(o_grant), 2);
        i_mem_valid = 1'b1;
        #1;
        check_val("rstg_dc_valid", 32'(o_dc_valid), 1);
        i_rst = 1'b1;
        cyc();
        check_val("rstg_grant", 32'(o_grant), 0);
        check_val("rstg_strobes", 32'({o_mem_ren, o_mem_wen}), 0);
        check_val("rstg_dc_valid0", 32'(o_dc_valid), 0);
        check_val("rstg_mem_addr", o_mem_addr, 0);
        check_val("rstg_mem_wdata", o_mem_wdata, 0);
        i_rst       = 1'b0;
        i_dc_ren    = 1'b0;
        i_mem_valid = 1'b0;
        cyc();

        // dcache holds wen for 20 cycles while the icache waits
        i_dc_wen = 1'b1;
        i_ic_ren = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc();
            check_val($sformatf("long_dc_%0d", i), 32'(o_grant), 2);
        end
        i_dc_wen = 1'b0;
        cyc();
        check_val("long_release_ic", 32'(o_grant), 1);
        i_dc_wen = 1'b1;
        cyc();
        check_val("long_ic_keeps", 32'(o_grant), 1);
        i_ic_ren = 1'b0;
        cyc();
        check_val("long_back_dc", 32'(o_grant), 2);
        i_dc_wen = 1'b0;
        cyc();
        check_val("long_end_idle", 32'(o_grant), 0);

        // starved icache wins a fresh contention from IDLE
        do_reset();
        i_dc_ren = 1'b1;
        i_ic_ren = 1'b1;
        for (int i = 0; i < 17; i++) cyc();
        check_val("starve_dc_owner", 32'(o_grant), 2);
        i_dc_ren = 1'b0;
        i_ic_ren = 1'b0;
        cyc();
        check_val("starve_idle", 32'(o_grant), 0);
        i_dc_ren = 1'b1;
        i_ic_ren = 1'b1;
        cyc();
        check_val("starve_promoted", 32'(o_grant), 1);
        i_dc_ren = 1'b0;
        i_ic_ren = 1'b0;
        cyc();
        check_val("starve_end_idle", 32'(o_grant), 0);

        // contention right after a dcache tenure: priority mode decides
        i_dc_ren = 1'b1;
        cyc();
        check_val("tie_prep_dc", 32'(o_grant), 2);
        i_dc_ren = 1'b0;
        cyc();
        i_dc_ren = 1'b1;
        i_ic_ren = 1'b1;
        cyc();
`ifdef ARB_ROUND_ROBIN_EN
        exp_tie = 2'b01;
`else
        exp_tie = 2'b10;
`endif
        check_val("tie_after_dc", 32'(o_grant), 32'(exp_tie));
        i_dc_ren = 1'b0;
        i_ic_ren = 1'b0;
        cyc();
        check_val("tie_end_idle", 32'(o_grant), 0);

        // both re-requesting with 4-cycle bursts: grants alternate
        do_reset();
        i_dc_ren = 1'b1;
        i_ic_ren = 1'b1;
        n_seq    = 0;
        idle_cnt = 0;
        dc_cnt   = 0;
        ic_cnt   = 0;
        dc_off   = 1'b0;
        ic_off   = 1'b0;
        prev_g   = 2'b00;
        for (int i = 0; i < 24; i++) begin
            cyc();
            g = o_grant;
            if (g == 2'b00) idle_cnt++;
            if (g != prev_g && g != 2'b00 && n_seq < 8) begin
                seq[n_seq] = g;
                n_seq++;
            end
            prev_g = g;
            if (dc_off) begin
                i_dc_ren = 1'b1;
                dc_off   = 1'b0;
            end else if (g == 2'b10) begin
                dc_cnt++;
                if (dc_cnt == 4) begin
                    i_dc_ren = 1'b0;
                    dc_cnt   = 0;
                    dc_off   = 1'b1;
                end
            end
            if (ic_off) begin
                i_ic_ren = 1'b1;
                ic_off   = 1'b0;
            end else if (g == 2'b01) begin
                ic_cnt++;
                if (ic_cnt == 4) begin
                    i_ic_ren = 1'b0;
                    ic_cnt   = 0;
                    ic_off   = 1'b1;
                end
            end
        end
        check_val("alt_count", 32'(n_seq >= 4), 1);
        check_val("alt_0_dc", 32'(seq[0]), 2);
        check_val("alt_1_ic", 32'(seq[1]), 1);
        check_val("alt_2_dc", 32'(seq[2]), 2);
        check_val("alt_3_ic", 32'(seq[3]), 1);
        check_val("alt_no_idle", 32'(idle_cnt), 0);
        i_dc_ren = 1'b0;
        i_ic_ren = 1'b0;
        cyc();

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
